// File: rtl/vga_pkg.sv
// Shared text-mode VRAM constants, clear FSM states and read-return tags.
// Pure declarations: no latency or backpressure of its own.
package vga_pkg;
    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 30;
    localparam int VRAM_ADDR_W = 12;
    localparam int VRAM_DATA_W = 8;
    localparam int VRAM_CELLS  = TEXT_COLS * TEXT_ROWS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_VID  = 2'd1,
        SRC_HOST = 2'd2
    } rd_src_t;
endpackage

// File: rtl/vram_clear_seq.sv
// Clear-screen sequencer: writes the fill byte to every cell, one per unstalled cycle.
// Busy from the cycle after start; stall_i holds the pointer; done pulses after the last write.
module vram_clear_seq
    import vga_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int CELLS  = VRAM_CELLS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] fill_i,
    input  logic              stall_i,
    output logic              wr_vld_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_dat_o,
    output logic              busy_o,
    output logic              done_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            fill_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        fill_d   = fill_q;
        done_d   = 1'b0;
        wr_vld_o = (state_q == CLEAR) && !stall_i;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    fill_d  = fill_i;
                end
            end
            CLEAR: begin
                // A start pulse here is deliberately not looked at.
                if (wr_vld_o) begin
                    if (ptr_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign wr_addr_o = ptr_q;
    assign wr_dat_o  = fill_q;
    assign busy_o    = (state_q == CLEAR);
    assign done_o    = done_q;
endmodule

// File: rtl/vram_arbiter.sv
// Screen-RAM arbiter, fixed priority video > clear > host; reads return 1 cycle after issue.
// Host is back-pressured (host_ready=0) by video or an active clear. Option: VRAM_ARB_STATS_EN.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int COLS   = TEXT_COLS,
    parameter int ROWS   = TEXT_ROWS,
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_fill,
    output logic              clr_busy,
    output logic              clr_done,
`ifdef VRAM_ARB_STATS_EN
    output logic [15:0]       host_stall_cnt,
`endif
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam int CELLS = COLS * ROWS;

    logic              clr_wr_vld;
    logic [ADDR_W-1:0] clr_wr_addr;
    logic [DATA_W-1:0] clr_wr_dat;
    logic              host_fire, host_in_range;
    rd_src_t           tag_q, tag_d;
    logic              oor_q, oor_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [DATA_W-1:0] host_ret;

    vram_clear_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CELLS  (CELLS)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (reset),
        .start_i   (clr_start),
        .fill_i    (clr_fill),
        .stall_i   (vid_req),
        .wr_vld_o  (clr_wr_vld),
        .wr_addr_o (clr_wr_addr),
        .wr_dat_o  (clr_wr_dat),
        .busy_o    (clr_busy),
        .done_o    (clr_done)
    );

    assign host_ready    = !vid_req && !clr_busy && reset;
    assign host_fire     = host_valid && host_ready;
    assign host_in_range = (32'(host_addr) < CELLS);

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = host_addr;
        ram_din  = host_wdata;
        tag_d    = SRC_NONE;
        oor_d    = 1'b0;
        if (vid_req) begin
            ram_addr = vid_addr;
            tag_d    = SRC_VID;
        end else if (clr_wr_vld) begin
            ram_we   = 1'b1;
            ram_addr = clr_wr_addr;
            ram_din  = clr_wr_dat;
        end else if (host_fire) begin
            ram_we = host_we && host_in_range;
            if (!host_we) begin
                tag_d = SRC_HOST;
                oor_d = !host_in_range;
            end
        end
        ram_we = ram_we && reset;
    end

    // Returned data is passed straight through on its valid cycle and held afterwards.
    assign host_ret     = oor_q ? '0 : ram_dout;
    assign vid_valid    = (tag_q == SRC_VID);
    assign host_rvalid  = (tag_q == SRC_HOST);
    assign vid_data_d   = vid_valid ? ram_dout : vid_data_q;
    assign host_rdata_d = host_rvalid ? host_ret : host_rdata_q;
    assign vid_data     = vid_data_d;
    assign host_rdata   = host_rdata_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q        <= SRC_NONE;
            oor_q        <= 1'b0;
            vid_data_q   <= '0;
            host_rdata_q <= '0;
        end else begin
            tag_q        <= tag_d;
            oor_q        <= oor_d;
            vid_data_q   <= vid_data_d;
            host_rdata_q <= host_rdata_d;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_start && !clr_busy) begin
            stall_cnt_d = '0;
        end else if (host_valid && !host_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign host_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: vector table, directed clear/reset sequences, randomized model check.
module tb_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vid_req = 1'b0;
    logic [11:0] vid_addr = '0;
    logic [7:0]  vid_data;
    logic        vid_valid;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic        host_we = 1'b0;
    logic [11:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic        host_rvalid;
    logic        clr_start = 1'b0;
    logic [7:0]  clr_fill = '0;
    logic        clr_busy;
    logic        clr_done;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] mem [4096];
    int         wcnt [2400];
    logic [7:0] shadow [2400];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .clr_start(clr_start), .clr_fill(clr_fill), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        vid_req    = 1'b0;
        host_valid = 1'b0;
        host_we    = 1'b0;
        clr_start  = 1'b0;
    endtask

    typedef struct {
        logic        vid;
        logic [11:0] vaddr;
        logic        hv;
        logic        we;
        logic [11:0] ha;
        logic [7:0]  wd;
        logic        e_rdy;
        logic        e_we;
        logic [11:0] e_addr;
        logic        e_vv;
        logic        e_rv;
        logic [7:0]  e_dat;
    } vec_t;

    // Starts a clear (with a concurrent host write to cell 7) and runs it to completion.
    task automatic run_clear(input logic [7:0] fill, input int vid_period, input bit poke,
                             output int busy, output int dones, output int stalls);
        logic [7:0] exp_v;
        busy = 0; dones = 0; stalls = 0;
        foreach (wcnt[i]) wcnt[i] = 0;
        @(negedge clk);
        clr_start = 1'b1; clr_fill = fill;
        host_valid = 1'b1; host_we = 1'b1; host_addr = 12'd7; host_wdata = 8'h99;
        #1;
        chk("start_host_ready", host_ready, 1);
        chk("start_host_we", ram_we, 1);
        chk("start_host_addr", ram_addr, 7);
        @(posedge clk); #1;
        chk("busy_after_start", clr_busy, 1);
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            idle_inputs();
            clr_start = poke && (c == 100);
            clr_fill  = 8'hEE;
            vid_req   = (vid_period > 0) && (c % vid_period == vid_period - 1);
            vid_addr  = 12'($urandom_range(2399));
            #1;
            exp_v = mem[vid_addr];
            if (vid_req) stalls++;
            if (ram_we && ram_addr < 12'd2400) wcnt[ram_addr]++;
            if (clr_busy) busy++;
            @(posedge clk); #1;
            if (vid_req) begin
                chk("clear_vid_valid", vid_valid, 1);
                chk("clear_vid_data", vid_data, exp_v);
            end
            if (clr_done) begin
                dones++;
                break;
            end
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        chk("done_single_pulse", clr_done, 0);
        chk("busy_after_done", clr_busy, 0);
    endtask

    task automatic check_fill(input string name, input logic [7:0] fill);
        int bad_w = 0, bad_v = 0;
        for (int a = 0; a < 2400; a++) begin
            if (wcnt[a] != 1) bad_w++;
            if (mem[a] !== fill) bad_v++;
        end
        chk({name, "_cells_written_once"}, bad_w, 0);
        chk({name, "_cells_filled"}, bad_v, 0);
    endtask

    initial begin
        vec_t tbl[8];
        int busy, dones, stalls, rd_cnt;
        bit found;
        logic [7:0] m_vid_hold, m_host_hold;
        logic e_vv, e_rv, acc;

        tbl[0] = '{1'b0, 12'd0,   1'b1, 1'b1, 12'd100,  8'hA5, 1'b1, 1'b1, 12'd100,  1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 12'd0,   1'b1, 1'b0, 12'd100,  8'h00, 1'b1, 1'b0, 12'd100,  1'b0, 1'b1, 8'hA5};
        tbl[2] = '{1'b1, 12'd100, 1'b1, 1'b0, 12'd200,  8'h00, 1'b0, 1'b0, 12'd100,  1'b1, 1'b0, 8'hA5};
        tbl[3] = '{1'b0, 12'd0,   1'b1, 1'b1, 12'd2400, 8'h11, 1'b1, 1'b0, 12'd2400, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 12'd0,   1'b1, 1'b0, 12'd4095, 8'h00, 1'b1, 1'b0, 12'd4095, 1'b0, 1'b1, 8'h00};
        tbl[5] = '{1'b0, 12'd0,   1'b1, 1'b1, 12'd0,    8'h3C, 1'b1, 1'b1, 12'd0,    1'b0, 1'b0, 8'h00};
        tbl[6] = '{1'b1, 12'd0,   1'b0, 1'b0, 12'd0,    8'h00, 1'b0, 1'b0, 12'd0,    1'b1, 1'b0, 8'h3C};
        tbl[7] = '{1'b0, 12'd0,   1'b1, 1'b0, 12'd0,    8'h00, 1'b1, 1'b0, 12'd0,    1'b0, 1'b1, 8'h3C};

        #1;
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_host_ready", host_ready, 0);
        chk("rst_vid_data", vid_data, 0);
        chk("rst_host_rdata", host_rdata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vid_req = tbl[i].vid; vid_addr = tbl[i].vaddr;
            host_valid = tbl[i].hv; host_we = tbl[i].we;
            host_addr = tbl[i].ha; host_wdata = tbl[i].wd;
            #1;
            chk($sformatf("vec%0d_ready", i), host_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_ram_we", i), ram_we, tbl[i].e_we);
            chk($sformatf("vec%0d_ram_addr", i), ram_addr, tbl[i].e_addr);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_vid_valid", i), vid_valid, tbl[i].e_vv);
            chk($sformatf("vec%0d_host_rvalid", i), host_rvalid, tbl[i].e_rv);
            if (tbl[i].e_vv) chk($sformatf("vec%0d_vid_data", i), vid_data, tbl[i].e_dat);
            if (tbl[i].e_rv) chk($sformatf("vec%0d_host_rdata", i), host_rdata, tbl[i].e_dat);
        end

        // Host read held across three video cycles, accepted on the fourth.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vid_req = (i < 3); vid_addr = 12'd100;
            host_valid = 1'b1; host_we = 1'b0; host_addr = 12'd0;
            #1;
            chk($sformatf("stall%0d_ready", i), host_ready, (i == 3));
            @(posedge clk); #1;
            chk($sformatf("stall%0d_vid_valid", i), vid_valid, (i < 3));
            chk($sformatf("stall%0d_host_rvalid", i), host_rvalid, (i == 3));
            if (i == 3) chk("stall_host_rdata", host_rdata, 8'h3C);
            else chk($sformatf("stall%0d_vid_data", i), vid_data, 8'hA5);
        end

        run_clear(8'h20, 0, 1'b1, busy, dones, stalls);
        chk("clr20_done_count", dones, 1);
        chk("clr20_busy_cycles", busy, 2400);
        check_fill("clr20", 8'h20);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            host_valid = 1'b1; host_we = 1'b0; host_addr = (i == 0) ? 12'd0 : 12'd2399;
            #1;
            chk("clr20_rd_ready", host_ready, 1);
            @(posedge clk); #1;
            chk("clr20_rd_rvalid", host_rvalid, 1);
            chk($sformatf("clr20_rd_addr%0d", host_addr), host_rdata, 8'h20);
        end

        run_clear(8'h41, 8, 1'b0, busy, dones, stalls);
        chk("clr41_done_count", dones, 1);
        chk("clr41_busy_cycles", busy, 2400 + stalls);
        chk("clr41_some_stalls", (stalls > 250), 1);
        check_fill("clr41", 8'h41);

        // Reset asserted while the clear pointer sits at 1000.
        @(negedge clk);
        idle_inputs();
        clr_start = 1'b1; clr_fill = 8'h55;
        @(negedge clk);
        clr_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk); #1;
            if (ram_we && ram_addr == 12'd1000) found = 1'b1;
        end
        chk("rst_mid_reached_1000", found, 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_mid_busy", clr_busy, 0);
        chk("rst_mid_done", clr_done, 0);
        chk("rst_mid_ram_we", ram_we, 0);
        rd_cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (clr_done) rd_cnt++;
        end
        chk("rst_mid_no_done", rd_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 12'd1500;
        #1;
        chk("rst_mid_host_ready", host_ready, 1);
        @(posedge clk); #1;
        chk("rst_mid_rvalid", host_rvalid, 1);
        chk("rst_mid_cell1500", host_rdata, 8'h41);
        chk("rst_mid_cell999", mem[999], 8'h55);
        chk("rst_mid_cell1000", mem[1000], 8'h41);

        run_clear(8'h00, 0, 1'b0, busy, dones, stalls);
        chk("clr00_done_count", dones, 1);
        foreach (shadow[i]) shadow[i] = 8'h00;
        m_vid_hold  = 8'h00;
        m_host_hold = 8'h41;

        // Randomized traffic against a screen-level model.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            vid_req    = ($urandom_range(99) < 30);
            vid_addr   = 12'($urandom_range(2399));
            host_valid = ($urandom_range(99) < 60);
            host_we    = $urandom_range(1) == 1;
            host_addr  = ($urandom_range(9) == 0) ? 12'($urandom_range(4095, 2400))
                                                  : 12'($urandom_range(2399));
            host_wdata = 8'($urandom);
            #1;
            acc = host_valid && !vid_req;
            chk("rnd_ready", host_ready, !vid_req);
            chk("rnd_ram_we", ram_we, acc && host_we && (host_addr < 12'd2400));
            e_vv = vid_req;
            e_rv = acc && !host_we;
            if (vid_req) m_vid_hold = shadow[vid_addr];
            if (e_rv) m_host_hold = (host_addr < 12'd2400) ? shadow[host_addr] : 8'h00;
            if (acc && host_we && host_addr < 12'd2400) shadow[host_addr] = host_wdata;
            @(posedge clk); #1;
            chk("rnd_vid_valid", vid_valid, e_vv);
            chk("rnd_vid_data", vid_data, m_vid_hold);
            chk("rnd_host_rvalid", host_rvalid, e_rv);
            chk("rnd_host_rdata", host_rdata, m_host_hold);
        end

        @(negedge clk);
        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
